phv_action_engine: RTL and testbench
====================================

# phv_action_engine

Per-stage action unit of the match-action pipeline. Takes one PHV (packet header vector) and the action word produced by that stage's lookup engine. Applies a single ALU or forwarding operation to one PHV container or metadata field, then presents the updated PHV to the next stage with a fixed two-cycle latency.

## Interface
Parameters:
- STAGE, 0: stage index; identification only, no functional effect.
- PHV_LEN, 1579: PHV width (1024 container + 7 + 192 metadata + 100 + 256).
- ACTION_LEN, 25: action word width.

Ports:
- axis_clk  in  1  sole clock; all logic rising-edge.
- aresetn  in  1  reset, synchronous, active-low.
- action_in  in  ACTION_LEN  action word from lookup engine.
- action_in_valid  in  1  qualifies action_in and phv_in for one cycle.
- phv_in  in  PHV_LEN  input PHV.
- phv_out  out  PHV_LEN  processed PHV.
- phv_out_valid  out  1  one-cycle strobe qualifying phv_out.

## Operation
PHV layout (bit 1578 = MSB):
- 4B[i], i=0..7: bits [1578-32i -: 32].
- 2B[i]: bits [1322-16i -: 16].
- 6B[i]: bits [1194-48i -: 48].
- Remaining container bits [810:555] and the flags field [554:548] pass through unchanged.
- Metadata [547:356]:
  - [547:540] egress port.
  - [539] discard flag.
  - Rest pass through.
- Bits [355:0] pass through unchanged.

Action word:
- op = [24:21].
- Operand A / destination: type [20:19], index [18:16].
- Operand B: type [15:14], index [13:11].
- imm = [15:0].
- Type encoding: 00 = 4B, 01 = 2B, 10 = 6B, 11 = invalid.

Opcodes:
- 0001 add: dst = A + B.
- 0010 sub: dst = A − B.
- 0011 addi: dst = A + imm.
- 0100 subi: dst = A − imm.
- 1000 redirect: egress port = action[18:11].
- 1001 discard: discard flag = 1.
- All others (incl. 0000): no-op; PHV passes unchanged.

Arithmetic rules:
- Computed at destination container width, wrap-around modulo 2^width, no saturation, no flags.
- imm is zero-extended to 32 or 48 bits; for 2B it is used full-width.
- Operand B of a different type from A is zero-extended, or truncated to its low bits, to A's width.
- Any referenced operand of type 11: entire operation becomes a no-op.
- Only the destination field changes; every other PHV bit is copied bit-exact.

## Timing
- Reset (aresetn low at clock edge): phv_out = 0, phv_out_valid = 0, pipeline registers cleared.
- Reset asserted mid-operation discards in-flight PHVs; no output strobe for them.
- Pipeline:
  - Cycle N: action_in_valid=1 samples action_in and phv_in.
  - N+1: operand extract registered.
  - N+2: phv_out updated, phv_out_valid=1 for exactly one cycle.
- Fully pipelined: a new valid input is accepted every cycle; back-to-back inputs produce back-to-back outputs in order.
- No backpressure, no ready signal.
- Inputs while action_in_valid=0 are ignored.
- phv_out holds its last value while phv_out_valid=0.

## Configuration
- ACTION_FWD_EN defined: redirect (1000) and discard (1001) are implemented as above.
- ACTION_FWD_EN undefined: opcodes 1000/1001 decode as no-ops and metadata is never modified. ALU opcodes are unaffected.

## Test plan
- Reset then idle: phv_out=0 and phv_out_valid=0 throughout; action_in=0x0000FF with valid=0 → no strobe.
- Nop: action_in=0, phv_in=2, valid for 1 cycle → 2 cycles later phv_out=2, valid=1 for one cycle.
- add: action {0001,00,000,00,001,11'b0}, 4B[0]=0xF0000000, 4B[1]=0 → 4B[0]=0xF0000000, all else unchanged. Also with 4B[1]=0x10000001 → 4B[0]=0x00000001 (wrap).
- addi/subi: action {0011,00,000,16'h0003}, 4B[0]=0xF0000000 → 0xF0000003. subi imm 1 on 2B[2]=0x0000 → 0xFFFF.
- Forwarding (ACTION_FWD_EN): redirect with action[18:11]=0x05 → bits[547:540]=0x05; discard → bit 539=1. Without the macro → PHV unchanged.
- Throughput/reset: 3 back-to-back valid actions → 3 consecutive correct outputs. Reset asserted one cycle after an input → no output strobe, phv_out=0.

Source files
------------

// File: rtl/phv_action_engine.sv
// Per-stage action unit: one ALU or forwarding op on a PHV field (redirect/discard need ACTION_FWD_EN).
// Latency 2 cycles, fully pipelined; no backpressure, a valid input is accepted every cycle.
module phv_action_engine #(
  parameter int STAGE      = 0,
  parameter int PHV_LEN    = 1579,
  parameter int ACTION_LEN = 25
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_in_valid,
  input  logic [PHV_LEN-1:0]    phv_in,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid
);

  localparam int C4_TOP   = PHV_LEN - 1;
  localparam int C2_TOP   = PHV_LEN - 257;
  localparam int C6_TOP   = PHV_LEN - 385;
  localparam int PORT_TOP = PHV_LEN - 1032;
  localparam int DISC_BIT = PHV_LEN - 1040;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_SUBI = 4'b0100;
  localparam logic [1:0] T_INV   = 2'b11;

  if (STAGE < 0 || ACTION_LEN != 25) begin : g_param_err
    $error("phv_action_engine: unsupported STAGE/ACTION_LEN");
  end

  function automatic logic [47:0] get_fld(input logic [PHV_LEN-1:0] p,
                                          input logic [1:0] t,
                                          input logic [2:0] i);
    logic [47:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      if (i == 3'(k)) begin
        case (t)
          2'b00:   v = {16'b0, p[C4_TOP-32*k -: 32]};
          2'b01:   v = {32'b0, p[C2_TOP-16*k -: 16]};
          2'b10:   v = p[C6_TOP-48*k -: 48];
          default: v = '0;
        endcase
      end
    end
    return v;
  endfunction

  logic [3:0]  op;
  logic [1:0]  a_type, b_type;
  logic [2:0]  a_idx, b_idx;
  logic [15:0] imm;
  logic        is_imm, is_alu;

  assign op     = action_in[24:21];
  assign a_type = action_in[20:19];
  assign a_idx  = action_in[18:16];
  assign b_type = action_in[15:14];
  assign b_idx  = action_in[13:11];
  assign imm    = action_in[15:0];

  logic               vld1_d, vld1_q;
  logic [PHV_LEN-1:0] phv1_d, phv1_q;
  logic               alu1_d, alu1_q, sub1_d, sub1_q;
  logic               redir1_d, redir1_q, disc1_d, disc1_q;
  logic [1:0]         dtype1_d, dtype1_q;
  logic [2:0]         didx1_d, didx1_q;
  logic [47:0]        a1_d, a1_q, b1_d, b1_q;
  logic [7:0]         port1_d, port1_q;

  // Stage 1: operand B is fetched zero-extended to 48 bits; truncation to A's width happens at write-back.
  always_comb begin
    is_imm   = (op == OP_ADDI) || (op == OP_SUBI);
    is_alu   = is_imm || (op == OP_ADD) || (op == OP_SUB);
    vld1_d   = action_in_valid;
    phv1_d   = phv_in;
    dtype1_d = a_type;
    didx1_d  = a_idx;
    a1_d     = get_fld(phv_in, a_type, a_idx);
    b1_d     = is_imm ? {32'b0, imm} : get_fld(phv_in, b_type, b_idx);
    alu1_d   = is_alu && (a_type != T_INV) && (is_imm || (b_type != T_INV));
    sub1_d   = (op == OP_SUB) || (op == OP_SUBI);
    port1_d  = action_in[18:11];
`ifdef ACTION_FWD_EN
    redir1_d = (op == 4'b1000);
    disc1_d  = (op == 4'b1001);
`else
    redir1_d = 1'b0;
    disc1_d  = 1'b0;
`endif
  end

  logic [47:0]        res;
  logic [PHV_LEN-1:0] phv_upd;
  logic [PHV_LEN-1:0] phv_out_d, phv_out_q;
  logic               phv_out_valid_d, phv_out_valid_q;

  always_comb begin
    res     = sub1_q ? (a1_q - b1_q) : (a1_q + b1_q);
    phv_upd = phv1_q;
    if (alu1_q) begin
      for (int k = 0; k < 8; k++) begin
        if (didx1_q == 3'(k)) begin
          case (dtype1_q)
            2'b00:   phv_upd[C4_TOP-32*k -: 32] = res[31:0];
            2'b01:   phv_upd[C2_TOP-16*k -: 16] = res[15:0];
            2'b10:   phv_upd[C6_TOP-48*k -: 48] = res;
            default: phv_upd = phv1_q;
          endcase
        end
      end
    end
    if (redir1_q) phv_upd[PORT_TOP -: 8] = port1_q;
    if (disc1_q)  phv_upd[DISC_BIT] = 1'b1;
    phv_out_d       = vld1_q ? phv_upd : phv_out_q;
    phv_out_valid_d = vld1_q;
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      vld1_q          <= 1'b0;
      phv1_q          <= '0;
      alu1_q          <= 1'b0;
      sub1_q          <= 1'b0;
      redir1_q        <= 1'b0;
      disc1_q         <= 1'b0;
      dtype1_q        <= '0;
      didx1_q         <= '0;
      a1_q            <= '0;
      b1_q            <= '0;
      port1_q         <= '0;
      phv_out_q       <= '0;
      phv_out_valid_q <= 1'b0;
    end else begin
      vld1_q          <= vld1_d;
      phv1_q          <= phv1_d;
      alu1_q          <= alu1_d;
      sub1_q          <= sub1_d;
      redir1_q        <= redir1_d;
      disc1_q         <= disc1_d;
      dtype1_q        <= dtype1_d;
      didx1_q         <= didx1_d;
      a1_q            <= a1_d;
      b1_q            <= b1_d;
      port1_q         <= port1_d;
      phv_out_q       <= phv_out_d;
      phv_out_valid_q <= phv_out_valid_d;
    end
  end

  assign phv_out       = phv_out_q;
  assign phv_out_valid = phv_out_valid_q;

endmodule

// File: tb/tb_phv_action_engine.sv
// Directed bench for phv_action_engine: hand-computed PHV results, latency, throughput and reset.
module tb_phv_action_engine;

  localparam int PHV_LEN    = 1579;
  localparam int ACTION_LEN = 25;
  typedef logic [PHV_LEN-1:0]    phv_t;
  typedef logic [ACTION_LEN-1:0] act_t;

  logic axis_clk = 1'b0;
  logic aresetn;
  logic action_in_valid;
  act_t action_in;
  phv_t phv_in;
  phv_t phv_out;
  logic phv_out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 axis_clk = ~axis_clk;

  phv_action_engine #(.STAGE(0), .PHV_LEN(PHV_LEN), .ACTION_LEN(ACTION_LEN)) dut (
    .axis_clk        (axis_clk),
    .aresetn         (aresetn),
    .action_in       (action_in),
    .action_in_valid (action_in_valid),
    .phv_in          (phv_in),
    .phv_out         (phv_out),
    .phv_out_valid   (phv_out_valid)
  );

  task automatic chk(input string tag, input phv_t obs, input phv_t exp);
    phv_t d, t, ow, ew;
    int hi, lo;
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      d  = obs ^ exp;
      hi = 0;
      for (int k = 0; k < PHV_LEN; k++) begin
        t = d >> k;
        if (t[0] !== 1'b0) hi = k;
      end
      lo = (hi > 63) ? hi - 63 : 0;
      ow = obs >> lo;
      ew = exp >> lo;
      $display("FAIL %s: bits [%0d:%0d] got %h want %h", tag, lo + 63, lo, ow[63:0], ew[63:0]);
    end
  endtask

  function automatic phv_t put(input phv_t p, input int lsb, input int w, input logic [47:0] v);
    phv_t m;
    m = ((phv_t'(1) << w) - phv_t'(1)) << lsb;
    return (p & ~m) | ((phv_t'(v) << lsb) & m);
  endfunction

  function automatic int l4(input int i); return 1547 - 32 * i; endfunction
  function automatic int l2(input int i); return 1307 - 16 * i; endfunction
  function automatic int l6(input int i); return 1147 - 48 * i; endfunction

  // One transaction: strobe at +2 cycles, then one idle cycle with phv_out held.
  task automatic run_one(input string tag, input act_t a, input phv_t p, input phv_t e);
    action_in       = a;
    phv_in          = p;
    action_in_valid = 1'b1;
    @(negedge axis_clk);
    action_in_valid = 1'b0;
    action_in       = '1;
    phv_in          = ~p;
    @(negedge axis_clk);
    chk({tag, " vld"}, phv_t'(phv_out_valid), phv_t'(1'b1));
    chk({tag, " phv"}, phv_out, e);
    @(negedge axis_clk);
    chk({tag, " vld_off"}, phv_t'(phv_out_valid), phv_t'(1'b0));
    chk({tag, " hold"}, phv_out, e);
  endtask

  phv_t base, p, e;
  act_t bb_a [3];
  phv_t bb_p [3];
  phv_t bb_e [3];

  initial begin
    base = '0;
    for (int k = 0; k < 50; k++) base = (base << 32) | phv_t'(32'(k + 1) * 32'h9E37_79B1);
    base = put(base, 540, 8, 48'hAA);
    base = put(base, 539, 1, 48'h0);

    aresetn         = 1'b0;
    action_in_valid = 1'b0;
    action_in       = '0;
    phv_in          = '0;
    repeat (3) @(negedge axis_clk);
    chk("reset vld", phv_t'(phv_out_valid), phv_t'(1'b0));
    chk("reset phv", phv_out, '0);

    aresetn   = 1'b1;
    action_in = act_t'(25'h0000FF);
    phv_in    = base;
    for (int c = 0; c < 3; c++) begin
      @(negedge axis_clk);
      chk("idle vld", phv_t'(phv_out_valid), phv_t'(1'b0));
      chk("idle phv", phv_out, '0);
    end

    run_one("nop", '0, phv_t'(2), phv_t'(2));

    p = put(put(base, l4(0), 32, 48'hF000_0000), l4(1), 32, 48'h0);
    run_one("add0", {4'b0001, 2'b00, 3'd0, 2'b00, 3'd1, 11'd0}, p, p);
    p = put(p, l4(1), 32, 48'h1000_0001);
    e = put(p, l4(0), 32, 48'h0000_0001);
    run_one("add_wrap", {4'b0001, 2'b00, 3'd0, 2'b00, 3'd1, 11'd0}, p, e);

    bb_a[0] = {4'b0011, 2'b00, 3'd0, 16'h0003};
    bb_p[0] = put(base, l4(0), 32, 48'hF000_0000);
    bb_e[0] = put(bb_p[0], l4(0), 32, 48'hF000_0003);
    run_one("addi", bb_a[0], bb_p[0], bb_e[0]);

    bb_a[1] = {4'b0100, 2'b01, 3'd2, 16'h0001};
    bb_p[1] = put(base, l2(2), 16, 48'h0);
    bb_e[1] = put(bb_p[1], l2(2), 16, 48'hFFFF);
    run_one("subi_2b", bb_a[1], bb_p[1], bb_e[1]);

    bb_a[2] = {4'b0010, 2'b10, 3'd7, 2'b01, 3'd0, 11'd0};
    bb_p[2] = put(put(base, l6(7), 48, 48'h5), l2(0), 16, 48'h7);
    bb_e[2] = put(bb_p[2], l6(7), 48, 48'hFFFF_FFFF_FFFE);
    run_one("sub_6b_2b", bb_a[2], bb_p[2], bb_e[2]);

    p = put(put(base, l2(1), 16, 48'h1), l4(3), 32, 48'h1234_FFFF);
    e = put(p, l2(1), 16, 48'h0);
    run_one("add_2b_trunc", {4'b0001, 2'b01, 3'd1, 2'b00, 3'd3, 11'd0}, p, e);

    run_one("inv_type", {4'b0001, 2'b00, 3'd0, 2'b11, 3'd0, 11'd0}, base, base);
    run_one("op_0101", {4'b0101, 21'h1F_FFFF}, base, base);

`ifdef ACTION_FWD_EN
    run_one("redirect", {4'b1000, 2'b00, 8'h05, 11'd0}, base, put(base, 540, 8, 48'h05));
    run_one("discard", {4'b1001, 21'd0}, base, put(base, 539, 1, 48'h1));
`else
    run_one("redirect", {4'b1000, 2'b00, 8'h05, 11'd0}, base, base);
    run_one("discard", {4'b1001, 21'd0}, base, base);
`endif

    action_in = bb_a[0]; phv_in = bb_p[0]; action_in_valid = 1'b1;
    @(negedge axis_clk);
    action_in = bb_a[1]; phv_in = bb_p[1];
    @(negedge axis_clk);
    action_in = bb_a[2]; phv_in = bb_p[2];
    chk("b2b0 vld", phv_t'(phv_out_valid), phv_t'(1'b1));
    chk("b2b0 phv", phv_out, bb_e[0]);
    @(negedge axis_clk);
    action_in_valid = 1'b0;
    chk("b2b1 vld", phv_t'(phv_out_valid), phv_t'(1'b1));
    chk("b2b1 phv", phv_out, bb_e[1]);
    @(negedge axis_clk);
    chk("b2b2 vld", phv_t'(phv_out_valid), phv_t'(1'b1));
    chk("b2b2 phv", phv_out, bb_e[2]);
    @(negedge axis_clk);
    chk("b2b end vld", phv_t'(phv_out_valid), phv_t'(1'b0));

    action_in = bb_a[0]; phv_in = bb_p[0]; action_in_valid = 1'b1;
    @(negedge axis_clk);
    action_in_valid = 1'b0;
    aresetn         = 1'b0;
    @(negedge axis_clk);
    chk("rst_mid vld", phv_t'(phv_out_valid), phv_t'(1'b0));
    chk("rst_mid phv", phv_out, '0);
    aresetn = 1'b1;
    @(negedge axis_clk);
    chk("rst_post vld", phv_t'(phv_out_valid), phv_t'(1'b0));
    chk("rst_post phv", phv_out, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
